// File: rtl/inst_mem_fetch.sv
// inst_mem_fetch: handshaked, parametrised instruction memory for the IF stage.
// Returns FETCH_INSTS consecutive little-endian instructions per request after
// WAIT_CYCLES wait states. Misaligned and out-of-range requests produce an
// explicit fault code and NOP-filled slots. Supports one outstanding request
// and a flush input for branch redirects.

module inst_mem_fetch #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    INST_WIDTH      = 32,
    parameter int                    FETCH_INSTS     = 1,
    parameter int                    MEM_DEPTH_BYTES = 4096,
    parameter int                    WAIT_CYCLES     = 0,
    parameter logic [INST_WIDTH-1:0] NOP_INST        = 32'h0000_0013,
    parameter string                 INIT_FILE       = ""
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [ADDR_WIDTH-1:0]             req_addr,
    input  logic                              flush,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [FETCH_INSTS*INST_WIDTH-1:0] rsp_inst,
    output logic [ADDR_WIDTH-1:0]             rsp_addr,
    output logic [1:0]                        rsp_fault,
    output logic                              busy
);

    localparam int BYTES       = INST_WIDTH / 8;
    localparam int FETCH_BYTES = FETCH_INSTS * BYTES;
    localparam int MEM_AW      = (MEM_DEPTH_BYTES > 1) ? $clog2(MEM_DEPTH_BYTES) : 1;

    localparam logic [1:0] FAULT_OK    = 2'b00;
    localparam logic [1:0] FAULT_ALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Byte-wide storage; contents are not affected by reset.
    logic [7:0] mem [MEM_DEPTH_BYTES];

    state_t                              state_r;
    logic [3:0]                          wait_cnt_r;
    logic [1:0]                          fault_s;
    logic                                accept_s;
    logic [FETCH_INSTS*INST_WIDTH-1:0]   data_s;

    // Classify a request address. The end address is formed one bit wider than
    // the address so a request near the top of the address space cannot wrap
    // back into the valid range. Misalignment wins over out-of-range.
    function automatic logic [1:0] calc_fault(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH:0] last_byte;
        last_byte = {1'b0, addr} + (ADDR_WIDTH+1)'(FETCH_BYTES - 1);
        if ((addr % ADDR_WIDTH'(BYTES)) != '0) begin
            calc_fault = FAULT_ALIGN;
        end else if (last_byte >= (ADDR_WIDTH+1)'(MEM_DEPTH_BYTES)) begin
            calc_fault = FAULT_RANGE;
        end else begin
            calc_fault = FAULT_OK;
        end
    endfunction

    assign fault_s   = calc_fault(req_addr);
    assign req_ready = !flush && ((state_r == ST_IDLE) || ((state_r == ST_RESP) && rsp_ready));
    assign accept_s  = req_valid && req_ready;

    // Assemble the little-endian fetch group; faulted requests get NOP in every slot.
    always_comb begin
        data_s = '0;
        if (fault_s != FAULT_OK) begin
            data_s = {FETCH_INSTS{NOP_INST}};
        end else begin
            for (int i = 0; i < FETCH_INSTS; i++) begin
                for (int b = 0; b < BYTES; b++) begin
                    data_s[i*INST_WIDTH + b*8 +: 8] =
                        mem[req_addr[MEM_AW-1:0] + MEM_AW'(i*BYTES + b)];
                end
            end
        end
    end

    // Request/response FSM with registered outputs; flush overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 4'd0;
            rsp_valid  <= 1'b0;
            rsp_inst   <= '0;
            rsp_addr   <= '0;
            rsp_fault  <= 2'b00;
            busy       <= 1'b0;
        end else if (flush) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 4'd0;
            rsp_valid  <= 1'b0;
            busy       <= 1'b0;
        end else if (accept_s) begin
            rsp_addr  <= req_addr;
            rsp_fault <= fault_s;
            rsp_inst  <= data_s;
            busy      <= 1'b1;
            if (WAIT_CYCLES == 0) begin
                state_r    <= ST_RESP;
                wait_cnt_r <= 4'd0;
                rsp_valid  <= 1'b1;
            end else begin
                state_r    <= ST_WAIT;
                wait_cnt_r <= 4'(WAIT_CYCLES);
                rsp_valid  <= 1'b0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                end
                ST_WAIT: begin
                    if (wait_cnt_r == 4'd1) begin
                        state_r    <= ST_RESP;
                        wait_cnt_r <= 4'd0;
                        rsp_valid  <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_r   <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        rsp_valid <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    wait_cnt_r <= 4'd0;
                    rsp_valid  <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem_fetch.sv
// Testbench for inst_mem_fetch: two configurations (no wait states / single
// instruction, and three wait states / two instructions) driven by directed
// sequences followed by randomized traffic, checked against a transaction-level
// model built from the memory image and the timing rules.

module tb_inst_mem_fetch;

    localparam int AW    = 32;
    localparam int IW    = 32;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int FI = (g == 0) ? 1 : 2;
        localparam int WC = (g == 0) ? 0 : 3;

        logic          rst_n, req_valid, req_ready, flush, rsp_valid, rsp_ready, busy;
        logic [AW-1:0] req_addr, rsp_addr;
        logic [FI*IW-1:0] rsp_inst;
        logic [1:0]    rsp_fault;

        logic [7:0]    img [DEPTH];

        // model state: one outstanding transaction, timed by edge counts
        bit            outst;
        int            acc_edge;
        int            edge_cnt;
        logic [63:0]   e_inst;
        logic [31:0]   e_addr;
        logic [1:0]    e_fault;

        inst_mem_fetch #(
            .ADDR_WIDTH(AW), .INST_WIDTH(IW), .FETCH_INSTS(FI),
            .MEM_DEPTH_BYTES(DEPTH), .WAIT_CYCLES(WC),
            .NOP_INST(32'h0000_0013), .INIT_FILE("")
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
            .req_addr(req_addr), .flush(flush), .rsp_valid(rsp_valid),
            .rsp_ready(rsp_ready), .rsp_inst(rsp_inst), .rsp_addr(rsp_addr),
            .rsp_fault(rsp_fault), .busy(busy)
        );

        // Expected response for a request address, straight from the rules.
        function automatic void model_rsp(input logic [31:0] a, output logic [63:0] d,
                                          output logic [1:0] f);
            logic [63:0] last;
            logic [31:0] w;
            last = {32'd0, a} + 64'(FI*4 - 1);
            d = '0;
            if ((a % 32'd4) != 32'd0)    f = 2'b01;
            else if (last >= 64'(DEPTH)) f = 2'b10;
            else                         f = 2'b00;
            for (int i = 0; i < FI; i++) begin
                if (f != 2'b00) w = 32'h0000_0013;
                else w = {img[a+4*i+3], img[a+4*i+2], img[a+4*i+1], img[a+4*i]};
                d[i*32 +: 32] = w;
            end
        endfunction

        // One clock cycle: drive at negedge, check, advance model, return at next negedge.
        task automatic step(input logic v, input logic [31:0] a, input logic fl, input logic rr);
            logic valid_now, exp_ready;
            req_valid = v; req_addr = a; flush = fl; rsp_ready = rr;
            #1;
            valid_now = outst && (edge_cnt >= acc_edge + WC);
            exp_ready = !fl && (!outst || (valid_now && rr));
            check_val($sformatf("c%0d_req_ready", g), 64'(req_ready), 64'(exp_ready));
            check_val($sformatf("c%0d_rsp_valid", g), 64'(rsp_valid), 64'(valid_now));
            check_val($sformatf("c%0d_busy", g), 64'(busy), 64'(outst));
            if (valid_now) begin
                check_val($sformatf("c%0d_rsp_inst@%h", g, e_addr), 64'(rsp_inst), e_inst);
                check_val($sformatf("c%0d_rsp_addr", g), 64'(rsp_addr), 64'(e_addr));
                check_val($sformatf("c%0d_rsp_fault@%h", g, e_addr), 64'(rsp_fault), 64'(e_fault));
            end
            if (fl) begin
                outst = 1'b0;
            end else if (v && exp_ready) begin
                outst    = 1'b1;
                acc_edge = edge_cnt + 1;
                e_addr   = a;
                model_rsp(a, e_inst, e_fault);
            end else if (valid_now && rr) begin
                outst = 1'b0;
            end
            @(posedge clk);
            edge_cnt++;
            @(negedge clk);
        endtask

        initial begin
            logic [31:0] a;
            rst_n = 1'b0; req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b0; req_addr = '0;
            outst = 1'b0; acc_edge = 0; edge_cnt = 0;
            e_inst = '0; e_addr = '0; e_fault = '0;
            for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
            img[0] = 8'h13; img[1] = 8'h05; img[2] = 8'h00; img[3] = 8'h00;
            for (int i = 0; i < DEPTH; i++) u_dut.mem[i] = img[i];

            #2;
            check_val($sformatf("c%0d_rst_valid", g), 64'(rsp_valid), 64'd0);
            check_val($sformatf("c%0d_rst_busy", g), 64'(busy), 64'd0);
            check_val($sformatf("c%0d_rst_inst", g), 64'(rsp_inst), 64'd0);
            check_val($sformatf("c%0d_rst_addr", g), 64'(rsp_addr), 64'd0);
            check_val($sformatf("c%0d_rst_fault", g), 64'(rsp_fault), 64'd0);
            @(negedge clk);
            rst_n = 1'b1;

            // basic fetch at 0, then backpressure with a pending request held off
            step(1'b1, 32'h0, 1'b0, 1'b0);
            repeat (WC) step(1'b0, 32'h0, 1'b0, 1'b0);
            check_val($sformatf("c%0d_basic_valid", g), 64'(rsp_valid), 64'd1);
            check_val($sformatf("c%0d_basic_inst", g), 64'(rsp_inst[31:0]), 64'h0000_0513);
            repeat (5) step(1'b1, 32'h10, 1'b0, 1'b0);
            step(1'b0, 32'h0, 1'b0, 1'b1);

            // back-to-back fetches with the consumer always ready
            step(1'b1, 32'h0, 1'b0, 1'b1);
            step(1'b1, 32'h8, 1'b0, 1'b1);
            repeat (WC + 2) step(1'b0, 32'h0, 1'b0, 1'b1);

            // faults: misaligned, top of memory, wrap-around
            step(1'b1, 32'h2, 1'b0, 1'b1);
            repeat (WC + 1) step(1'b0, 32'h0, 1'b0, 1'b1);
            step(1'b1, 32'(DEPTH - 4), 1'b0, 1'b1);
            repeat (WC + 1) step(1'b0, 32'h0, 1'b0, 1'b1);
            step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
            repeat (WC) step(1'b0, 32'h0, 1'b0, 1'b0);
            check_val($sformatf("c%0d_wrap_fault", g), 64'(rsp_fault), 64'h2);
            step(1'b0, 32'h0, 1'b0, 1'b1);

            // flush right after accept, then flush with a request present
            step(1'b1, 32'h10, 1'b0, 1'b1);
            step(1'b0, 32'h0, 1'b1, 1'b1);
            repeat (WC + 2) step(1'b0, 32'h0, 1'b0, 1'b1);
            step(1'b1, 32'h14, 1'b1, 1'b1);
            step(1'b1, 32'h14, 1'b0, 1'b1);
            repeat (WC + 1) step(1'b0, 32'h0, 1'b0, 1'b1);

            // randomized traffic
            for (int n = 0; n < 1500; n++) begin
                case ($urandom_range(0, 9))
                    0:       a = $urandom;
                    1:       a = (32'($urandom_range(0, DEPTH/4 - 1)) << 2) | 32'($urandom_range(1, 3));
                    2:       a = 32'(DEPTH) - 32'(4 * $urandom_range(0, 2));
                    3:       a = 32'hFFFF_FFFC;
                    default: a = 32'(4 * $urandom_range(0, DEPTH/4 - FI));
                endcase
                step($urandom_range(0, 9) < 7, a, $urandom_range(0, 11) == 0,
                     $urandom_range(0, 9) < 7);
            end

            // asynchronous reset while a request is in flight
            step(1'b0, 32'h0, 1'b0, 1'b1);
            repeat (WC + 1) step(1'b0, 32'h0, 1'b0, 1'b1);
            step(1'b1, 32'h10, 1'b0, 1'b0);
            #2;
            rst_n = 1'b0;
            #1;
            check_val($sformatf("c%0d_arst_valid", g), 64'(rsp_valid), 64'd0);
            check_val($sformatf("c%0d_arst_busy", g), 64'(busy), 64'd0);
            outst = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            repeat (WC + 4) step(1'b0, 32'h0, 1'b0, 1'b0);

            done_cnt++;
        end
    end

    initial begin
        for (int c = 0; c < 20000 && done_cnt < 2; c++) @(posedge clk);
        check_val("completion", 64'(done_cnt), 64'd2);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
